// File: rtl/rv32_id_stage.sv
// rv32_id_stage: RV32I decode, register-file read selects, ID/EX register and load-use interlock.
// Latency: 1 cycle from IF/ID acceptance to ex_valid; register-file read data lands alongside it.
// Backpressure: ex_ready=0 holds ID/EX and drops id_ready; flush kills ID/EX and the incoming word.
//
// Optional feature macro: RV32_ID_LOAD_USE_STALL_EN. When defined, a load in ID/EX whose rd feeds
// the instruction in IF/ID inserts one bubble. When undefined, hazard is tied low, id_ready follows
// ex_ready, and load-use ordering is left to the compiler or an external unit.
//
// Ports:
//   clk, rst                  pipeline clock; synchronous active-high reset
//   if_valid, if_instr, if_pc IF/ID instruction offer
//   id_ready                  ID accepts if_instr this cycle (combinational)
//   flush                     EX redirect: kill ID/EX and the incoming instruction
//   ex_ready                  EX can take a new ID/EX entry
//   sel_s1, sel_s2            register-file read selects (combinational)
//   ex_*                      ID/EX pipeline register: valid, pc, imm, indices, raw fields, controls
module rv32_id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  output logic        id_ready,
  input  logic        flush,
  input  logic        ex_ready,
  output logic [4:0]  sel_s1,
  output logic [4:0]  sel_s2,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_rd,
  output logic [4:0]  ex_rs1,
  output logic [4:0]  ex_rs2,
  output logic [6:0]  ex_opcode,
  output logic [2:0]  ex_funct3,
  output logic        ex_funct7b5,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_reg_write,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic        ex_alu_src_imm,
  output logic        ex_illegal
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // ID/EX payload (everything except the valid bit)
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        branch;
    logic        jump;
    logic        alu_src_imm;
    logic        illegal;
  } idex_t;

  idex_t dec;
  idex_t ex_q;
  logic  ex_valid_q;
  logic  hazard;

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
  assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
  assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25],
                  if_instr[11:8], 1'b0};
  assign imm_u = {if_instr[31:12], 12'b0};
  assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20],
                  if_instr[30:21], 1'b0};

  // Decode of the instruction currently offered by IF/ID
  always_comb begin
    dec          = '0;
    dec.pc       = if_pc;
    dec.rd       = if_instr[11:7];
    dec.rs1      = if_instr[19:15];
    dec.rs2      = if_instr[24:20];
    dec.opcode   = if_instr[6:0];
    dec.funct3   = if_instr[14:12];
    dec.funct7b5 = if_instr[30];
    case (if_instr[6:0])
      OPC_LUI, OPC_AUIPC: begin
        dec.imm         = imm_u;
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
      end
      OPC_JAL: begin
        dec.imm         = imm_j;
        dec.reg_write   = 1'b1;
        dec.jump        = 1'b1;
        dec.alu_src_imm = 1'b1;
      end
      OPC_JALR: begin
        dec.imm         = imm_i;
        dec.reg_write   = 1'b1;
        dec.jump        = 1'b1;
        dec.alu_src_imm = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm    = imm_b;
        dec.branch = 1'b1;
      end
      OPC_LOAD: begin
        dec.imm         = imm_i;
        dec.mem_read    = 1'b1;
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
      end
      OPC_STORE: begin
        dec.imm         = imm_s;
        dec.mem_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
      end
      OPC_OPIMM: begin
        dec.imm         = imm_i;
        dec.reg_write   = 1'b1;
        dec.alu_src_imm = 1'b1;
      end
      OPC_OP: begin
        dec.reg_write = 1'b1;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
    // x0 is hardwired; never request a writeback to it
    if (if_instr[11:7] == 5'd0) dec.reg_write = 1'b0;
  end

`ifdef RV32_ID_LOAD_USE_STALL_EN
  logic [6:0] opc;
  logic       rs1_used, rs2_used;

  assign opc      = if_instr[6:0];
  assign rs1_used = (opc == OPC_JALR) || (opc == OPC_BRANCH) || (opc == OPC_LOAD) ||
                    (opc == OPC_STORE) || (opc == OPC_OPIMM) || (opc == OPC_OP);
  assign rs2_used = (opc == OPC_BRANCH) || (opc == OPC_STORE) || (opc == OPC_OP);

  // Load data only exists after MEM, so a consumer directly behind a load must wait one slot
  assign hazard = ex_valid_q && ex_q.mem_read && (ex_q.rd != 5'd0) && if_valid &&
                  ((rs1_used && (if_instr[19:15] == ex_q.rd)) ||
                   (rs2_used && (if_instr[24:20] == ex_q.rd)));
`else
  assign hazard = 1'b0;
`endif

  assign id_ready = ex_ready && !hazard;

  // While EX stalls, the held entry re-reads its own sources so late writebacks are seen
  assign sel_s1 = ex_ready ? if_instr[19:15] : ex_q.rs1;
  assign sel_s2 = ex_ready ? if_instr[24:20] : ex_q.rs2;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      ex_q       <= '0;
    end else if (flush) begin
      ex_valid_q <= 1'b0;
    end else if (ex_ready) begin
      if (hazard) begin
        ex_valid_q <= 1'b0;
      end else if (if_valid) begin
        ex_valid_q <= 1'b1;
        ex_q       <= dec;
      end else begin
        ex_valid_q <= 1'b0;
      end
    end
  end

  assign ex_valid       = ex_valid_q;
  assign ex_pc          = ex_q.pc;
  assign ex_imm         = ex_q.imm;
  assign ex_rd          = ex_q.rd;
  assign ex_rs1         = ex_q.rs1;
  assign ex_rs2         = ex_q.rs2;
  assign ex_opcode      = ex_q.opcode;
  assign ex_funct3      = ex_q.funct3;
  assign ex_funct7b5    = ex_q.funct7b5;
  assign ex_mem_read    = ex_q.mem_read;
  assign ex_mem_write   = ex_q.mem_write;
  assign ex_reg_write   = ex_q.reg_write;
  assign ex_branch      = ex_q.branch;
  assign ex_jump        = ex_q.jump;
  assign ex_alu_src_imm = ex_q.alu_src_imm;
  assign ex_illegal     = ex_q.illegal;

endmodule

// File: tb/tb_rv32_id_stage.sv
// tb_rv32_id_stage: self-checking bench for rv32_id_stage.
// Expected ID/EX entries are queued when a transfer is offered and compared when they appear.
// Directed sequences cover reset, load-use, x0 loads, back-pressure, flush and illegal opcodes.
module tb_rv32_id_stage;

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        id_ready;
  logic        flush;
  logic        ex_ready;
  logic [4:0]  sel_s1, sel_s2;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_imm;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump;
  logic        ex_alu_src_imm, ex_illegal;

  rv32_id_stage dut (
    .clk(clk), .rst(rst),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .id_ready(id_ready),
    .flush(flush), .ex_ready(ex_ready),
    .sel_s1(sel_s1), .sel_s2(sel_s2),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_opcode(ex_opcode), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_alu_src_imm(ex_alu_src_imm),
    .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model of one ID/EX entry
  typedef struct {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rd, rs1, rs2;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        f7b5;
    logic [6:0]  ctl; // {mem_read, mem_write, reg_write, branch, jump, alu_src_imm, illegal}
  } exp_t;

  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    logic [31:0] sh20, sh19, sh11;
    sh20 = $signed(ins) >>> 20;
    sh19 = $signed(ins) >>> 19;
    sh11 = $signed(ins) >>> 11;
    e.pc = pc; e.rd = ins[11:7]; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
    e.opc = ins[6:0]; e.f3 = ins[14:12]; e.f7b5 = ins[30];
    case (ins[6:0])
      7'h37, 7'h17: begin e.imm = ins & 32'hFFFF_F000; e.ctl = 7'b0010010; end
      7'h6F: begin
        e.imm = (sh11 & 32'hFFF0_0000) | ({24'd0, ins[19:12]} << 12) |
                ({31'd0, ins[20]} << 11) | ({22'd0, ins[30:21]} << 1);
        e.ctl = 7'b0010110;
      end
      7'h67: begin e.imm = sh20; e.ctl = 7'b0010110; end
      7'h63: begin
        e.imm = (sh19 & 32'hFFFF_F000) | ({31'd0, ins[7]} << 11) |
                ({26'd0, ins[30:25]} << 5) | ({28'd0, ins[11:8]} << 1);
        e.ctl = 7'b0001000;
      end
      7'h03: begin e.imm = sh20; e.ctl = 7'b1010010; end
      7'h23: begin e.imm = (sh20 & ~32'h1F) | {27'd0, ins[11:7]}; e.ctl = 7'b0100010; end
      7'h13: begin e.imm = sh20; e.ctl = 7'b0010010; end
      7'h33: begin e.imm = 32'd0; e.ctl = 7'b0010000; end
      default: begin e.imm = 32'd0; e.ctl = 7'b0000001; end
    endcase
    if (ins[11:7] == 5'd0) e.ctl[4] = 1'b0;
    return e;
  endfunction

  exp_t sb_q[$];
  bit   exp_valid = 1'b0;
  bit   cap_last  = 1'b0;

  // Scoreboard: outputs at the falling edge reflect the last rising edge; then predict the next one
  always @(negedge clk) begin : mon
    exp_t e;
    bit   cap;
    chk("ex_valid_track", ex_valid, exp_valid);
    if (cap_last) begin
      chk("sb_nonempty", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_pc", ex_pc, e.pc);
        chk("sb_imm", ex_imm, e.imm);
        chk("sb_rd", 32'(ex_rd), 32'(e.rd));
        chk("sb_rs1", 32'(ex_rs1), 32'(e.rs1));
        chk("sb_rs2", 32'(ex_rs2), 32'(e.rs2));
        chk("sb_opcode", 32'(ex_opcode), 32'(e.opc));
        chk("sb_funct", 32'({ex_funct3, ex_funct7b5}), 32'({e.f3, e.f7b5}));
        chk("sb_ctl", 32'({ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump,
                           ex_alu_src_imm, ex_illegal}), 32'(e.ctl));
      end
    end
    cap = !rst && !flush && ex_ready && if_valid && id_ready;
    if (cap) sb_q.push_back(model(if_instr, if_pc));
    if (rst || flush) exp_valid = 1'b0;
    else if (ex_ready) exp_valid = cap;
    cap_last = cap;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one instruction and wait for it to be accepted
  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    int n;
    n = 0;
    if_valid = 1'b1; if_instr = ins; if_pc = pc;
    #1;
    while (!id_ready && n < 16) begin
      step();
      n++;
    end
    chk("issue_bound", 32'(n < 16), 1);
    step();
    if_valid = 1'b0;
  endtask

  localparam logic [31:0] I_ADDI  = 32'hFFF0_0293; // addi x5,x0,-1
  localparam logic [31:0] I_LW6   = 32'h0000_A303; // lw   x6,0(x1)
  localparam logic [31:0] I_ADD76 = 32'h0023_03B3; // add  x7,x6,x2
  localparam logic [31:0] I_LW0   = 32'h0000_A003; // lw   x0,0(x1)
  localparam logic [31:0] I_ADD70 = 32'h0020_03B3; // add  x7,x0,x2
  localparam logic [31:0] I_BEQ   = 32'hFE20_8CE3; // beq  x1,x2,-8
  localparam logic [31:0] I_OR    = 32'h0041_E4B3; // or   x9,x3,x4
  localparam logic [31:0] I_BAD   = 32'h0000_057F; // opcode 0x7F, rd=10

  logic [31:0] prog [8] = '{32'h1234_51B7, 32'hFFFF_F217, 32'hFFDF_F0EF, 32'h0000_8067,
                            32'hFE51_2E23, 32'h40A4_8433, 32'h0041_9863, 32'h8000_2513};

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    if_valid = 1'b1; if_instr = I_ADDI; if_pc = 32'h100;
    step(); step();
    chk("rst_valid", ex_valid, 0);
    chk("rst_imm", ex_imm, 0);
    chk("rst_pc", ex_pc, 0);
    chk("rst_rd", 32'(ex_rd), 0);
    chk("rst_ctl", 32'({ex_reg_write, ex_alu_src_imm, ex_illegal, ex_mem_read}), 0);
    chk("rst_id_ready", id_ready, 1);

    rst = 1'b0;
    issue(I_ADDI, 32'h100);
    chk("addi_valid", ex_valid, 1);
    chk("addi_imm", ex_imm, 32'hFFFF_FFFF);
    chk("addi_rd", 32'(ex_rd), 5);
    chk("addi_regwr", ex_reg_write, 1);
    chk("addi_alusrc", ex_alu_src_imm, 1);
    chk("addi_pc", ex_pc, 32'h100);

    // load followed by a dependent ALU op
    issue(I_LW6, 32'h104);
    if_valid = 1'b1; if_instr = I_ADD76; if_pc = 32'h108;
    #1;
`ifdef RV32_ID_LOAD_USE_STALL_EN
    chk("lu_stall_ready", id_ready, 0);
    step();
    chk("lu_bubble", ex_valid, 0);
    chk("lu_ready_after", id_ready, 1);
    step();
`else
    chk("lu_nostall_ready", id_ready, 1);
    step();
`endif
    chk("lu_add_valid", ex_valid, 1);
    chk("lu_add_rs1", 32'(ex_rs1), 6);
    if_valid = 1'b0;

    // load to x0 never stalls and never writes back
    issue(I_LW0, 32'h10C);
    chk("lwx0_regwr", ex_reg_write, 0);
    chk("lwx0_memrd", ex_mem_read, 1);
    if_valid = 1'b1; if_instr = I_ADD70; if_pc = 32'h110;
    #1;
    chk("lwx0_ready", id_ready, 1);
    step();
    chk("lwx0_add_rd", 32'(ex_rd), 7);
    if_valid = 1'b0;

    // BEQ held under back-pressure while another instruction waits in IF/ID
    issue(I_BEQ, 32'h114);
    ex_ready = 1'b0;
    if_valid = 1'b1; if_instr = I_OR; if_pc = 32'h118;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_valid", ex_valid, 1);
      chk("bp_imm", ex_imm, 32'hFFFF_FFF8);
      chk("bp_pc", ex_pc, 32'h114);
      chk("bp_branch", ex_branch, 1);
      chk("bp_sel1", 32'(sel_s1), 1);
      chk("bp_sel2", 32'(sel_s2), 2);
      chk("bp_ready", id_ready, 0);
      step();
    end
    ex_ready = 1'b1;
    #1;
    chk("bp_rel_sel1", 32'(sel_s1), 3);
    chk("bp_rel_sel2", 32'(sel_s2), 4);
    step();
    chk("bp_or_rd", 32'(ex_rd), 9);
    if_valid = 1'b0;

    // flush together with a load-use hazard and a valid input
    issue(I_LW6, 32'h11C);
    if_valid = 1'b1; if_instr = I_ADD76; if_pc = 32'h120; flush = 1'b1;
    step();
    chk("flush_valid", ex_valid, 0);
    flush = 1'b0; if_valid = 1'b0;
    repeat (3) step();
    chk("flush_gone", ex_valid, 0);
    chk("flush_hold_rd", 32'(ex_rd), 6);

    // unknown opcode
    issue(I_BAD, 32'h124);
    chk("ill_flag", ex_illegal, 1);
    chk("ill_ctl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump}), 0);

    // mixed program with random back-pressure gaps
    for (int i = 0; i < 8; i++) begin
      if_valid = 1'b1; if_instr = prog[i]; if_pc = 32'h200 + 32'(4 * i);
      ex_ready = 1'b0;
      repeat ($urandom_range(0, 2)) step();
      ex_ready = 1'b1;
      issue(prog[i], 32'h200 + 32'(4 * i));
    end

    // reset mid-stream while back-pressured with a valid input
    issue(I_ADDI, 32'h300);
    ex_ready = 1'b0; if_valid = 1'b1; rst = 1'b1;
    step();
    chk("mrst_valid", ex_valid, 0);
    chk("mrst_imm", ex_imm, 0);
    rst = 1'b0; ex_ready = 1'b1; if_valid = 1'b0;

    repeat (3) step();
    chk("sb_drain", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32_id_stage.md
# rv32_id_stage

Instruction-decode stage of the 5-stage RV32I pipeline. Accepts fetched instructions from IF/ID, drives the register-file read selects, decodes control and immediates, and holds the ID/EX pipeline register. The register file registers its read data, so that data arrives in the same cycle as the ID/EX fields this block launches. The block also owns the load-use interlock and the flush/back-pressure handling at the ID/EX boundary.

## Interface
- No parameters; XLEN fixed at 32.
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  one clock; reset is synchronous and active-high
- if_valid  in  1  IF/ID holds a valid instruction
- if_instr  in  32  instruction word
- if_pc  in  32  PC of if_instr
- id_ready  out  1  ID accepts if_instr this cycle (combinational)
- flush  in  1  EX redirect; kill ID/EX contents and the incoming instruction
- ex_ready  in  1  EX can accept a new ID/EX entry this cycle
- sel_s1, sel_s2  out  5  register-file read selects (combinational)
- ex_valid  out  1  ID/EX entry valid
- ex_pc, ex_imm  out  32  PC; sign-extended immediate
- ex_rd, ex_rs1, ex_rs2  out  5  register indices
- ex_opcode  out  7; ex_funct3  out  3; ex_funct7b5  out  1  raw fields for the ALU decoder
- ex_mem_read, ex_mem_write, ex_reg_write, ex_branch, ex_jump, ex_alu_src_imm, ex_illegal  out  1 each  decoded controls

## Operation
- Opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
- Any other opcode sets ex_illegal=1 and forces all other controls to 0.
- Immediates:
  - I: instr[31:20]
  - S: {instr[31:25],instr[11:7]}
  - B: {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}
  - U: {instr[31:12],12'b0}
  - J: {instr[31],instr[19:12],instr[20],instr[30:21],1'b0}
  - All except U are sign-extended from bit 31. R-type immediate is 0.
- Register usage:
  - rs1 used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - rs2 used by BRANCH, STORE, OP.
  - ex_reg_write=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, but 0 when rd==0.
- Load-use hazard: ex_valid && ex_mem_read && ex_rd!=0 && if_valid && ((rs1 used && if_instr[19:15]==ex_rd) || (rs2 used && if_instr[24:20]==ex_rd)).
- id_ready = ex_ready && !hazard.
- Read selects:
  - sel_s1/sel_s2 = if_instr[19:15]/[24:20] when ex_ready=1.
  - Otherwise ex_rs1/ex_rs2, so a held entry re-reads the file and picks up writebacks.
- Edge update, in priority order:
  - rst: all ex_* outputs = 0.
  - flush: ex_valid=0; other fields hold.
  - !ex_ready: all ID/EX fields hold.
  - hazard: bubble, ex_valid=0; fields hold; IF/ID is held by id_ready=0.
  - if_valid: capture the decoded instruction, ex_valid=1.
  - else: ex_valid=0.
- Flush overrides a simultaneous hazard, back-pressure, or valid input; the incoming instruction is discarded.

## Timing
- Latency: 1 cycle from IF/ID acceptance to ex_valid.
- Register-file read data for the entry is valid in the same cycle as ex_valid.
- Load-use costs exactly one bubble. The dependent instruction issues on the cycle after the load leaves ID/EX.
- Handshake: a transfer occurs when if_valid && id_ready. if_instr must stay stable while if_valid && !id_ready.
- id_ready and sel_* are combinational from ex_ready, ex_* state and if_instr. There is no combinational path from flush.
- Reset mid-stream: ex_valid=0 on the next edge regardless of the other inputs.
- Reset values: every ex_* output is 0. id_ready reads as ex_ready, since ex_valid=0 means no hazard.

## Configuration
- RV32_ID_LOAD_USE_STALL_EN:
  - Defined: the interlock operates as specified above.
  - Undefined: hazard is tied to 0, id_ready = ex_ready, and load-use ordering becomes the responsibility of the compiler or of an external unit.

## Test plan
- Reset with if_valid=1: all ex_* = 0 and ex_valid=0 until the first edge after rst drops. Then ADDI x5,x0,-1 (0xFFF00293) gives ex_imm=0xFFFFFFFF, ex_rd=5, ex_reg_write=1, ex_alu_src_imm=1.
- LW x6,0(x1) followed by ADD x7,x6,x2:
  - Stall on: id_ready=0 for one cycle, one bubble (ex_valid=0), then ADD with ex_rs1=6.
  - Stall off: ADD issues back-to-back.
- LW x0,0(x1) followed by ADD x7,x0,x2: no stall. ex_reg_write=0 for the LW.
- ex_ready=0 for 3 cycles with BEQ (imm -8) held in ID/EX: fields stable and sel_s1/sel_s2 = ex_rs1/ex_rs2. ex_imm=0xFFFFFFF8 throughout.
- flush=1 in the same cycle as a hazard and if_valid=1: next ex_valid=0, and the incoming instruction does not appear later.
- Opcode 0x7F: ex_illegal=1, ex_reg_write=ex_mem_read=ex_mem_write=ex_branch=ex_jump=0.
